// File: rtl/io_bus_bridge_if.sv
// Handshake and IO-bus signal bundle between the byte-stream bridge and its neighbours.
// master = bridge side; slave = byte source/sink and bus responders.
interface io_bus_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] bus_addr;
  logic [7:0] bus_dout;
  logic       bus_w_en;
  logic       bus_r_en;
  logic [7:0] bus_din;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready,
    output tx_data, tx_valid,
    input  tx_ready,
    output bus_addr, bus_dout, bus_w_en, bus_r_en,
    input  bus_din
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready,
    input  tx_data, tx_valid,
    output tx_ready,
    input  bus_addr, bus_dout, bus_w_en, bus_r_en,
    output bus_din
  );
endinterface

// File: rtl/io_bus_bridge.sv
// Byte-stream command parser driving the peripheral IO bus; read results return as a byte stream.
// Commands: 'W' addr data, 'R' addr, 'B' addr count (count 0 = 256 sequential reads).
module io_bus_bridge #(
  parameter logic [7:0]  CMD_WRITE = 8'h57,
  parameter logic [7:0]  CMD_READ  = 8'h52,
  parameter logic [7:0]  CMD_BURST = 8'h42,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  io_bus_bridge_if.master     io,
  output logic                busy_o,
  output logic [7:0]          timeouts_o
);

  // state     | meaning
  // IDLE      | waiting for an opcode byte
  // GET_ADDR  | waiting for the address operand
  // GET_DATA  | waiting for the write data operand
  // GET_COUNT | waiting for the burst count operand
  // BUS_WR    | write strobe cycle
  // BUS_RD    | read strobe cycle
  // WAIT_RD   | responder data valid, captured at end of cycle
  // SEND      | presenting read byte until the sink takes it
  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_GET_COUNT,
    S_BUS_WR, S_BUS_RD, S_WAIT_RD, S_SEND
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  txd_q, txd_d;
  logic [15:0] tocnt_q, tocnt_d;
  logic [7:0]  timeouts_q, timeouts_d;

  logic        in_get;
  logic        rx_fire;
  logic [15:0] tocnt_inc;

  assign in_get    = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA) || (state_q == S_GET_COUNT);
  assign rx_fire   = io.rx_valid && io.rx_ready;
  assign tocnt_inc = tocnt_q + 16'd1;

  assign io.rx_ready = rst_i && ((state_q == S_IDLE) || in_get);
  assign io.tx_valid = (state_q == S_SEND);
  assign io.tx_data  = txd_q;
  assign io.bus_addr = addr_q;
  assign io.bus_dout = dout_q;
  assign io.bus_w_en = (state_q == S_BUS_WR);
  assign io.bus_r_en = (state_q == S_BUS_RD);
  assign busy_o      = (state_q != S_IDLE);
  assign timeouts_o  = timeouts_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      op_q       <= 8'h00;
      addr_q     <= 8'h00;
      dout_q     <= 8'h00;
      rem_q      <= 9'd0;
      txd_q      <= 8'h00;
      tocnt_q    <= 16'd0;
      timeouts_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      rem_q      <= rem_d;
      txd_q      <= txd_d;
      tocnt_q    <= tocnt_d;
      timeouts_q <= timeouts_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    rem_d      = rem_q;
    txd_d      = txd_q;
    tocnt_d    = tocnt_q;
    timeouts_d = timeouts_q;

    case (state_q)
      S_IDLE: begin
        tocnt_d = 16'd0;
        if (rx_fire && ((io.rx_data == CMD_WRITE) || (io.rx_data == CMD_READ) ||
                        (io.rx_data == CMD_BURST))) begin
          op_d    = io.rx_data;
          state_d = S_GET_ADDR;
        end
      end
      S_GET_ADDR: begin
        if (rx_fire) begin
          addr_d = io.rx_data;
          if (op_q == CMD_WRITE) begin
            state_d = S_GET_DATA;
          end else if (op_q == CMD_READ) begin
            rem_d   = 9'd1;
            state_d = S_BUS_RD;
          end else begin
            state_d = S_GET_COUNT;
          end
        end
      end
      S_GET_DATA: begin
        if (rx_fire) begin
          dout_d  = io.rx_data;
          state_d = S_BUS_WR;
        end
      end
      S_GET_COUNT: begin
        if (rx_fire) begin
          rem_d   = (io.rx_data == 8'h00) ? 9'd256 : {1'b0, io.rx_data};
          state_d = S_BUS_RD;
        end
      end
      S_BUS_WR: state_d = S_IDLE;
      S_BUS_RD: state_d = S_WAIT_RD;
      S_WAIT_RD: begin
        txd_d   = io.bus_din;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (io.tx_ready) begin
          rem_d = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = S_BUS_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Operand wait: any accepted byte restarts the count; TIMEOUT idle cycles abandon the command.
    if (in_get) begin
      if (rx_fire) begin
        tocnt_d = 16'd0;
      end else if (TIMEOUT != 16'd0) begin
        tocnt_d = tocnt_inc;
        if (tocnt_inc == TIMEOUT) begin
          tocnt_d = 16'd0;
          state_d = S_IDLE;
          if (timeouts_q != 8'hFF) timeouts_d = timeouts_q + 8'd1;
        end
      end
    end
  end

endmodule
